neuromorphic_x1_wb_bank_router: RTL and testbench
=================================================

// Module: neuromorphic_x1_wb_bank_router
// PURPOSE
//  Wishbone slave front-end fanning one bus port out to NUM_BANKS Neuromorphic_X1 core instances.
//  Decodes the bank field, holds one transaction outstanding, enforces a per-access timeout, and
//  returns error data on bad bank/sel or timeout. A local CSR window exposes sticky status and counters.
//  Sits between the SoC Wishbone interconnect and the per-bank Neuromorphic_X1_wb instances.
// PARAMETERS
//  NUM_BANKS      4         number of downstream cores (1..16)
//  BANK_LSB       16        LSB of bank index field in wbs_adr_i; field width = clog2(NUM_BANKS), min 1
//  CSR_BIT        23        wbs_adr_i bit selecting local CSR window (1 = CSR, 0 = bank)
//  TIMEOUT_CYCLES 255       max cycles waiting for downstream ack (1..65535)
//  ERR_DATA       32'hDEAD_0000  base read data on error; low 4 bits carry error code
// PORTS
//  wb_clk_i   in   1              bus clock; single clock domain
//  wb_rst_n   in   1              asynchronous active-low reset
//  wbs_stb_i  in   1              upstream strobe
//  wbs_cyc_i  in   1              upstream cycle
//  wbs_we_i   in   1              1 = write
//  wbs_sel_i  in   4              byte selects; only 4'hF legal for bank accesses
//  wbs_adr_i  in   32             address
//  wbs_dat_i  in   32             write data
//  wbs_dat_o  out  32             read data (registered)
//  wbs_ack_o  out  1              ack, single-cycle pulse (registered)
//  m_cyc_o    out  NUM_BANKS      per-bank cycle, one-hot or zero
//  m_stb_o    out  NUM_BANKS      per-bank strobe, equal to m_cyc_o
//  m_we_o     out  1              shared, captured wbs_we_i
//  m_sel_o    out  4              shared, captured wbs_sel_i
//  m_adr_o    out  32             shared, captured wbs_adr_i
//  m_dat_o    out  32             shared, captured wbs_dat_i
//  m_dat_i    in   32*NUM_BANKS   per-bank read data, bank b at [32*b +: 32]
//  m_ack_i    in   NUM_BANKS      per-bank ack
//  irq_o      out  1              level, high while any STATUS sticky bit set
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; STATUS, TO_CNT, LAST_ERR_ADR = 0. Reset mid-transaction drops m_cyc/m_stb at once, no ack.
//  FSM IDLE: on stb&cyc capture adr/dat/we/sel and decode:
//    CSR_BIT=1 -> RESP (CSR access performed in this transition).
//    bank index >= NUM_BANKS -> RESP, data ERR_DATA|1, set STATUS[0] BAD_BANK, LAST_ERR_ADR<=adr.
//    sel != 4'hF -> RESP, data ERR_DATA|2, set STATUS[1] BAD_SEL, LAST_ERR_ADR<=adr; no downstream access.
//    else -> ISSUE, assert m_cyc/m_stb[bank] next cycle; wait counter cleared.
//  ISSUE: hold m_* stable. m_ack_i[bank]=1 -> capture m_dat_i bank slice (reads) , drop m_cyc/m_stb, -> RESP.
//    Acks from non-selected banks ignored. Counter +1 per cycle; reaching TIMEOUT_CYCLES without ack ->
//    drop m_*, data ERR_DATA|3, set STATUS[2] TIMEOUT, TO_CNT +1 (saturate 16'hFFFF), LAST_ERR_ADR<=adr, -> RESP.
//    Ack and timeout same cycle: ack wins, no error. wbs_cyc_i low in ISSUE: abort, drop m_*, -> IDLE, no ack.
//  RESP: wbs_ack_o=1 for exactly one cycle with wbs_dat_o valid (0 for writes unless error) -> IDLE.
//  wbs_dat_o holds last value until next RESP. New request accepted in IDLE cycle after RESP (no overlap).
//  Latency (stb seen to ack): CSR/error = 2 cycles; bank = 2 + downstream ack latency (ack in ISSUE cycle k -> ack_o k+1).
//  CSR window (adr[3:2]): 0 STATUS [2:0] sticky, write-1-to-clear; 1 TO_CNT [15:0] RO, any write clears;
//    2 LAST_ERR_ADR RO; 3 ID = {16'h4E58, 8'(NUM_BANKS), 8'h02} RO. CSR writes ignore sel except == 0 (no-op).
//  Error set and W1C same cycle: set wins. irq_o registered from STATUS != 0.
// TESTING
//  Write 0x1234_5678 bank 2, core acks 3 cycles later -> m_stb_o=4'b0100 3 cycles, m_dat_o=0x1234_5678, one wbs_ack_o.
//  Read bank 0, core returns 0xA5A5_0001 -> wbs_dat_o=0xA5A5_0001 at ack, latency = 2 + core latency.
//  Read bank 3 with NUM_BANKS=3, then sel=4'h3 write bank 1 -> data 0xDEAD_0001, 0xDEAD_0002, STATUS=3'b011, irq_o=1, m_stb_o stays 0.
//  Bank 1 never acks, TIMEOUT_CYCLES=8 -> m_stb_o dropped after 8 cycles, data 0xDEAD_0003, TO_CNT=1, STATUS[2]=1.
//  Write STATUS=3'b111 -> STATUS=0, irq_o=0; error in same cycle as W1C -> bit stays set.
//  Drop wbs_cyc_i during ISSUE, and separately pulse wb_rst_n low during ISSUE -> m_* low, no wbs_ack_o, next access ok.

Source files
------------

// File: rtl/neuromorphic_x1_wb_bank_router.sv
// Wishbone slave front-end that routes one bus port to NUM_BANKS Neuromorphic_X1
// cores. One transaction in flight, per-access ack timeout, error responses for
// bad bank / bad byte-select / timeout, and a small local CSR window.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for stb&cyc; decodes CSR / bank / error in one step
// ISSUE | downstream cycle open on one bank, timeout running
// RESP  | wbs_ack_o high for this single cycle, wbs_dat_o valid
module neuromorphic_x1_wb_bank_router #(
    parameter int          NUM_BANKS      = 4,
    parameter int          BANK_LSB       = 16,
    parameter int          CSR_BIT        = 23,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_0000
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_n,
    input  logic                      wbs_stb_i,
    input  logic                      wbs_cyc_i,
    input  logic                      wbs_we_i,
    input  logic [3:0]                wbs_sel_i,
    input  logic [31:0]               wbs_adr_i,
    input  logic [31:0]               wbs_dat_i,
    output logic [31:0]               wbs_dat_o,
    output logic                      wbs_ack_o,
    output logic [NUM_BANKS-1:0]      m_cyc_o,
    output logic [NUM_BANKS-1:0]      m_stb_o,
    output logic                      m_we_o,
    output logic [3:0]                m_sel_o,
    output logic [31:0]               m_adr_o,
    output logic [31:0]               m_dat_o,
    input  logic [32*NUM_BANKS-1:0]   m_dat_i,
    input  logic [NUM_BANKS-1:0]      m_ack_i,
    output logic                      irq_o
);

    localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam logic [15:0] TMR_LOAD = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t               state_q, state_d;
    logic [NUM_BANKS-1:0] cyc_q, cyc_d;
    logic                 we_q, we_d;
    logic [3:0]           sel_q, sel_d;
    logic [31:0]          adr_q, adr_d;
    logic [31:0]          wdat_q, wdat_d;
    logic [31:0]          rdat_q, rdat_d;
    logic                 ack_q, ack_d;
    logic [15:0]          tmr_q, tmr_d;
    logic [2:0]           status_q, status_d;
    logic [15:0]          to_cnt_q, to_cnt_d;
    logic [31:0]          last_err_q, last_err_d;
    logic                 irq_q;

    logic [BW-1:0]        req_idx;
    logic                 bad_bank;
    logic [NUM_BANKS-1:0] req_hot;
    logic [31:0]          ack_dat;
    logic                 ack_hit;
    logic [31:0]          csr_rd;
    logic [2:0]           status_set;
    logic [2:0]           status_clr;

    // Bank decode of the incoming address and downstream ack/data selection.
    always_comb begin
        req_idx  = wbs_adr_i[BANK_LSB +: BW];
        bad_bank = ({1'b0, req_idx} >= (BW+1)'(NUM_BANKS));
        req_hot  = '0;
        ack_dat  = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            req_hot[b] = (req_idx == BW'(b));
            if (cyc_q[b]) ack_dat = m_dat_i[32*b +: 32];
        end
        // cyc_q is one-hot, so acks from any other bank are masked out here
        ack_hit = |(m_ack_i & cyc_q);
        case (wbs_adr_i[3:2])
            2'd0:    csr_rd = {29'd0, status_q};
            2'd1:    csr_rd = {16'd0, to_cnt_q};
            2'd2:    csr_rd = last_err_q;
            default: csr_rd = {16'h4E58, 8'(NUM_BANKS), 8'h02};
        endcase
    end

    // Next-state and datapath updates for the transaction FSM.
    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        we_d       = we_q;
        sel_d      = sel_q;
        adr_d      = adr_q;
        wdat_d     = wdat_q;
        rdat_d     = rdat_q;
        ack_d      = 1'b0;
        tmr_d      = tmr_q;
        to_cnt_d   = to_cnt_q;
        last_err_d = last_err_q;
        status_set = 3'b000;
        status_clr = 3'b000;
        case (state_q)
            IDLE: begin
                if (wbs_stb_i && wbs_cyc_i) begin
                    we_d   = wbs_we_i;
                    sel_d  = wbs_sel_i;
                    adr_d  = wbs_adr_i;
                    wdat_d = wbs_dat_i;
                    if (wbs_adr_i[CSR_BIT]) begin
                        state_d = RESP;
                        ack_d   = 1'b1;
                        rdat_d  = wbs_we_i ? 32'd0 : csr_rd;
                        if (wbs_we_i && (wbs_sel_i != 4'h0)) begin
                            if (wbs_adr_i[3:2] == 2'd0) status_clr = wbs_dat_i[2:0];
                            if (wbs_adr_i[3:2] == 2'd1) to_cnt_d = 16'd0;
                        end
                    end else if (bad_bank) begin
                        state_d       = RESP;
                        ack_d         = 1'b1;
                        rdat_d        = {ERR_DATA[31:4], 4'd1};
                        status_set[0] = 1'b1;
                        last_err_d    = wbs_adr_i;
                    end else if (wbs_sel_i != 4'hF) begin
                        state_d       = RESP;
                        ack_d         = 1'b1;
                        rdat_d        = {ERR_DATA[31:4], 4'd2};
                        status_set[1] = 1'b1;
                        last_err_d    = wbs_adr_i;
                    end else begin
                        state_d = ISSUE;
                        cyc_d   = req_hot;
                        tmr_d   = TMR_LOAD;
                    end
                end
            end
            ISSUE: begin
                if (!wbs_cyc_i) begin
                    state_d = IDLE;
                    cyc_d   = '0;
                end else if (ack_hit) begin
                    // ack takes priority over a timeout expiring in the same cycle
                    state_d = RESP;
                    cyc_d   = '0;
                    ack_d   = 1'b1;
                    rdat_d  = we_q ? 32'd0 : ack_dat;
                end else if (tmr_q == 16'd0) begin
                    state_d       = RESP;
                    cyc_d         = '0;
                    ack_d         = 1'b1;
                    rdat_d        = {ERR_DATA[31:4], 4'd3};
                    status_set[2] = 1'b1;
                    last_err_d    = adr_q;
                    if (to_cnt_q != 16'hFFFF) to_cnt_d = to_cnt_q + 16'd1;
                end else begin
                    tmr_d = tmr_q - 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // a set in the same cycle as a write-1-to-clear keeps the bit
        status_d = (status_q & ~status_clr) | status_set;
    end

    // State and datapath registers; reset drops any open downstream cycle at once.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q    <= IDLE;
            cyc_q      <= '0;
            we_q       <= 1'b0;
            sel_q      <= 4'h0;
            adr_q      <= 32'd0;
            wdat_q     <= 32'd0;
            rdat_q     <= 32'd0;
            ack_q      <= 1'b0;
            tmr_q      <= 16'd0;
            status_q   <= 3'b000;
            to_cnt_q   <= 16'd0;
            last_err_q <= 32'd0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            adr_q      <= adr_d;
            wdat_q     <= wdat_d;
            rdat_q     <= rdat_d;
            ack_q      <= ack_d;
            tmr_q      <= tmr_d;
            status_q   <= status_d;
            to_cnt_q   <= to_cnt_d;
            last_err_q <= last_err_d;
            irq_q      <= (status_q != 3'b000);
        end
    end

    assign wbs_dat_o = rdat_q;
    assign wbs_ack_o = ack_q;
    assign m_cyc_o   = cyc_q;
    assign m_stb_o   = cyc_q;
    assign m_we_o    = we_q;
    assign m_sel_o   = sel_q;
    assign m_adr_o   = adr_q;
    assign m_dat_o   = wdat_q;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_neuromorphic_x1_wb_bank_router.sv
// Directed bench for the bank router: three banks, timeout of 8 cycles.
module tb_neuromorphic_x1_wb_bank_router;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic [31:0] rdat;
    logic        ack;
    logic [2:0]  m_cyc, m_stb;
    logic        m_we;
    logic [3:0]  m_sel;
    logic [31:0] m_adr, m_dat;
    logic [95:0] m_dat_i;
    logic [2:0]  m_ack_i;
    logic        irq;

    int tests = 0;
    int fails = 0;

    // results of the last xfer
    logic [31:0] r_dat, r_mdat, r_madr;
    logic [2:0]  r_stb_or;
    logic        r_mwe, r_got, r_ack_after;
    int          r_lat, r_stb_cycles;

    localparam logic [31:0] CSR_STATUS = 32'h0080_0000;
    localparam logic [31:0] CSR_TOCNT  = 32'h0080_0004;
    localparam logic [31:0] CSR_LASTER = 32'h0080_0008;
    localparam logic [31:0] CSR_ID     = 32'h0080_000C;

    neuromorphic_x1_wb_bank_router #(
        .NUM_BANKS(3), .BANK_LSB(16), .CSR_BIT(23),
        .TIMEOUT_CYCLES(8), .ERR_DATA(32'hDEAD_0000)
    ) dut (
        .wb_clk_i(clk), .wb_rst_n(rst_n),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_dat_o(rdat), .wbs_ack_o(ack),
        .m_cyc_o(m_cyc), .m_stb_o(m_stb), .m_we_o(m_we), .m_sel_o(m_sel),
        .m_adr_o(m_adr), .m_dat_o(m_dat), .m_dat_i(m_dat_i), .m_ack_i(m_ack_i),
        .irq_o(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus transaction; the bench also plays the cores. core_lat = number of
    // m_stb cycles before the core acks (0 = never). noise = acks on other banks.
    // Called and returning at posedge+1.
    task automatic xfer(input logic w, input logic [3:0] s, input logic [31:0] a,
                        input logic [31:0] d, input int core_lat, input logic [2:0] noise);
        int edges;
        r_dat = '0; r_mdat = '0; r_madr = '0; r_mwe = 1'b0; r_stb_or = '0;
        r_got = 1'b0; r_lat = 0; r_stb_cycles = 0; edges = 0;
        stb = 1'b1; cyc = 1'b1; we = w; sel = s; adr = a; wdat = d;
        m_ack_i = noise;
        while (!r_got && edges < 50) begin
            @(posedge clk); #1;
            edges++;
            m_ack_i = noise;
            if (m_stb != 3'b000) begin
                r_stb_cycles++;
                r_stb_or = r_stb_or | m_stb;
                r_mdat = m_dat; r_madr = m_adr; r_mwe = m_we;
                if (core_lat > 0 && r_stb_cycles == core_lat) m_ack_i = m_stb | noise;
            end
            if (ack) begin
                r_got = 1'b1;
                r_dat = rdat;
                r_lat = edges + 1;
            end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0; m_ack_i = 3'b000;
        @(posedge clk); #1;
        r_ack_after = ack;
    endtask

    initial begin
        logic ack_seen;
        rst_n = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
        adr = '0; wdat = '0; m_ack_i = '0;
        m_dat_i = {32'h2222_2222, 32'h1111_1111, 32'hA5A5_0001};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_dat", rdat, 32'd0);
        chk("rst_stb", 32'(m_stb), 32'd0);
        chk("rst_cyc", 32'(m_cyc), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_adr", m_adr, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ID register, CSR latency
        xfer(1'b0, 4'hF, CSR_ID, 32'd0, 0, 3'b000);
        chk("id_got", 32'(r_got), 32'd1);
        chk("id_dat", r_dat, 32'h4E58_0302);
        chk("id_lat", 32'(r_lat), 32'd2);

        // write bank 2, core acks on its third strobe cycle
        xfer(1'b1, 4'hF, 32'h0002_0010, 32'h1234_5678, 3, 3'b000);
        chk("wr2_got", 32'(r_got), 32'd1);
        chk("wr2_stb_or", 32'(r_stb_or), 32'b100);
        chk("wr2_stb_cyc", 32'(r_stb_cycles), 32'd3);
        chk("wr2_mdat", r_mdat, 32'h1234_5678);
        chk("wr2_madr", r_madr, 32'h0002_0010);
        chk("wr2_mwe", 32'(r_mwe), 32'd1);
        chk("wr2_lat", 32'(r_lat), 32'd5);
        chk("wr2_dat", r_dat, 32'd0);
        chk("wr2_single_ack", 32'(r_ack_after), 32'd0);

        // read bank 0 with bank 1 acking continuously
        xfer(1'b0, 4'hF, 32'h0000_0040, 32'd0, 2, 3'b010);
        chk("rd0_dat", r_dat, 32'hA5A5_0001);
        chk("rd0_lat", 32'(r_lat), 32'd4);
        chk("rd0_stb_or", 32'(r_stb_or), 32'b001);
        chk("rd0_mwe", 32'(r_mwe), 32'd0);

        // bad bank, then bad sel
        xfer(1'b0, 4'hF, 32'h0003_0000, 32'd0, 1, 3'b000);
        chk("badbank_dat", r_dat, 32'hDEAD_0001);
        chk("badbank_lat", 32'(r_lat), 32'd2);
        chk("badbank_stb", 32'(r_stb_or), 32'd0);
        xfer(1'b1, 4'h3, 32'h0001_0020, 32'h5555_5555, 1, 3'b000);
        chk("badsel_dat", r_dat, 32'hDEAD_0002);
        chk("badsel_stb", 32'(r_stb_or), 32'd0);
        chk("err_irq", 32'(irq), 32'd1);
        xfer(1'b0, 4'hF, CSR_STATUS, 32'd0, 0, 3'b000);
        chk("status_011", r_dat, 32'd3);
        xfer(1'b0, 4'hF, CSR_LASTER, 32'd0, 0, 3'b000);
        chk("last_err_sel", r_dat, 32'h0001_0020);

        // bank 1 never acks
        xfer(1'b0, 4'hF, 32'h0001_0000, 32'd0, 0, 3'b000);
        chk("to_dat", r_dat, 32'hDEAD_0003);
        chk("to_stb_cyc", 32'(r_stb_cycles), 32'd8);
        chk("to_stb_or", 32'(r_stb_or), 32'b010);
        chk("to_stb_drop", 32'(m_stb), 32'd0);
        xfer(1'b0, 4'hF, CSR_TOCNT, 32'd0, 0, 3'b000);
        chk("to_cnt_1", r_dat, 32'd1);
        xfer(1'b0, 4'hF, CSR_STATUS, 32'd0, 0, 3'b000);
        chk("status_111", r_dat, 32'd7);
        xfer(1'b0, 4'hF, CSR_LASTER, 32'd0, 0, 3'b000);
        chk("last_err_to", r_dat, 32'h0001_0000);

        // W1C all status bits
        xfer(1'b1, 4'hF, CSR_STATUS, 32'h0000_0007, 0, 3'b000);
        chk("w1c_dat", r_dat, 32'd0);
        xfer(1'b0, 4'hF, CSR_STATUS, 32'd0, 0, 3'b000);
        chk("status_clr", r_dat, 32'd0);
        chk("irq_clr", 32'(irq), 32'd0);
        // sel==0 CSR write is a no-op; any other write clears TO_CNT
        xfer(1'b1, 4'h0, CSR_TOCNT, 32'd0, 0, 3'b000);
        xfer(1'b0, 4'hF, CSR_TOCNT, 32'd0, 0, 3'b000);
        chk("to_cnt_sel0", r_dat, 32'd1);
        xfer(1'b1, 4'h1, CSR_TOCNT, 32'd0, 0, 3'b000);
        xfer(1'b0, 4'hF, CSR_TOCNT, 32'd0, 0, 3'b000);
        chk("to_cnt_clr", r_dat, 32'd0);
        // error after clear sets the bit again
        xfer(1'b0, 4'hF, 32'h0003_0004, 32'd0, 0, 3'b000);
        xfer(1'b0, 4'hF, CSR_STATUS, 32'd0, 0, 3'b000);
        chk("status_reset", r_dat, 32'd1);

        // abort via cyc drop during ISSUE
        stb = 1'b1; cyc = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h0002_0000;
        @(posedge clk); #1;
        chk("abort_stb_up", 32'(m_stb), 32'b100);
        stb = 1'b0; cyc = 1'b0;
        ack_seen = 1'b0;
        @(posedge clk); #1;
        chk("abort_stb_drop", 32'(m_stb), 32'd0);
        ack_seen = ack;
        repeat (3) begin
            @(posedge clk); #1;
            ack_seen = ack_seen | ack;
        end
        chk("abort_no_ack", 32'(ack_seen), 32'd0);
        xfer(1'b0, 4'hF, 32'h0002_0000, 32'd0, 1, 3'b000);
        chk("abort_next_dat", r_dat, 32'h2222_2222);
        chk("abort_next_lat", 32'(r_lat), 32'd3);

        // reset pulse during ISSUE
        stb = 1'b1; cyc = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h0000_0000;
        @(posedge clk); #1;
        chk("rstmid_stb_up", 32'(m_stb), 32'b001);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_stb", 32'(m_stb), 32'd0);
        chk("rstmid_cyc", 32'(m_cyc), 32'd0);
        chk("rstmid_ack", 32'(ack), 32'd0);
        stb = 1'b0; cyc = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rstmid_ack2", 32'(ack), 32'd0);
        xfer(1'b0, 4'hF, CSR_STATUS, 32'd0, 0, 3'b000);
        chk("rstmid_status", r_dat, 32'd0);
        xfer(1'b0, 4'hF, 32'h0000_0008, 32'd0, 1, 3'b000);
        chk("rstmid_next_dat", r_dat, 32'hA5A5_0001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
